musb_mult_accum: RTL and testbench
==================================

# musb_mult_accum

Parametrised, 4-stage pipelined signed/unsigned multiplier with optional multiply-add/multiply-subtract, for the MUSB execute stage. Takes two WIDTH-bit operands plus a 2·WIDTH-bit accumulator operand and produces a 2·WIDTH-bit result. Each accepted operation gets exactly one result. Stall, flush, and activity signalling let the hazard unit track operations in flight.

## Interface
- WIDTH, 32: operand width. Must be even and ≥ 8. HALF = WIDTH/2.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- input_a  in  WIDTH  operand A.
- input_b  in  WIDTH  operand B.
- accum_in  in  2·WIDTH  accumulator operand (e.g. {HI,LO}), sampled with the operands.
- signed_operation  in  1  0 = unsigned, 1 = two's-complement operands (accum_in is treated as a raw bit pattern either way).
- op  in  2  00 MUL, 01 MADD (accum_in + A·B), 10 MSUB (accum_in − A·B), 11 treated as MUL.
- enable_op  in  1  valid operation on the inputs this cycle.
- stall  in  1  freeze every pipeline register.
- flush  in  1  synchronously kill all in-flight operations.
- mult_result  out  2·WIDTH  registered result.
- active  out  1  OR of the four stage-valid flags.
- ready  out  1  mult_result holds a valid result (stage-4 valid flag).

## Operation
- Stage 1
  - sign_x = signed_operation & x[WIDTH−1].
  - Register the magnitudes |A| and |B| as WIDTH+1 bits, so −2^(WIDTH−1) is represented exactly.
  - Register sign_p = sign_a ^ sign_b, op, accum_in, and valid = enable_op.
- Stage 2: register four partial products:
  - ll = A[HALF−1:0]·B[HALF−1:0]
  - lh = A[HALF−1:0]·B[WIDTH:HALF]
  - hl = A[WIDTH:HALF]·B[HALF−1:0]
  - hh = A[WIDTH−1:HALF]·B[WIDTH−1:HALF]
- Stage 3: register mid = lh + hl (WIDTH+1 bits); pass ll and hh through.
- Stage 4
  - Form magnitude P = {({hh, ll[WIDTH−1:HALF]} + mid), ll[HALF−1:0]}, truncated to 2·WIDTH.
  - Form the signed product SP = sign_p ? −P : P.
  - Register mult_result:
    - MUL: SP
    - MADD: accum_in + SP
    - MSUB: accum_in − SP
  - All sums are modulo 2^(2·WIDTH); no saturation and no overflow flag.
- The side-band signals (op, sign_p, accum_in, valid) travel with their operation, one stage per accepted edge.
- Pipeline advance
  - When stall=0 and flush=0, every stage advances.
  - When stall=1 and flush=0, nothing changes, including mult_result and the valid flags.
- Flush
  - flush=1 at an edge clears all four valid flags, whatever stall is.
  - Data registers keep their values.
  - An enable_op presented in that same cycle is dropped.
- Reset
  - rst asserted: all valid flags, sign flags and op registers, and mult_result go to 0 immediately, without waiting for a clock edge.
  - Outputs during reset: mult_result=0, active=0, ready=0.
  - Operations in flight at reset are discarded; no partial result is ever exposed.
  - Data registers other than mult_result need no reset.
- Bubbles: when enable_op=0 the computation still runs, but valid=0 and ready stays low for that slot.

## Timing
- Latency: an operation accepted at edge N (enable_op=1, stall=0) drives ready=1 with its mult_result after edge N+3.
  - "Accepted edges" count only edges with stall=0.
- Throughput: one operation per non-stalled cycle, back-to-back, with no internal bubbles.
- Each stalled cycle delays all in-flight results by exactly one cycle.
- ready stays high, holding its value, until the next non-stalled edge.
- active is high from the cycle after acceptance until the result leaves stage 4.
- The hazard unit must hold the dependent instruction while active=1 and ready=0.
- Simultaneous flush and stall: flush wins.
- Simultaneous rst and any input: rst wins.

## Configuration
- MUSB_MULT_ACCUM_EN
  - Defined: MADD/MSUB behave as above, and the accum_in/op pipeline registers are built.
  - Undefined:
    - op is ignored and every operation is MUL.
    - accum_in is unused and no accumulator registers or adder are built.
    - Latency and all handshake behaviour are identical.

## Test plan
- Unsigned MUL, WIDTH=32: A=0xFFFFFFFF, B=0xFFFFFFFF -> after 4 edges ready=1, result=0xFFFFFFFE00000001.
- Signed MUL, WIDTH=32:
  - A=0x80000000, B=0x80000000 -> 0x4000000000000000.
  - A=0xFFFFFFFF (−1), B=7 -> 0xFFFFFFFFFFFFFFF9.
- Accumulate (MUSB_MULT_ACCUM_EN defined), signed, WIDTH=32:
  - MADD accum_in=0x1, A=3, B=5 -> 0x10.
  - MSUB accum_in=0x0, A=2, B=3 -> 0xFFFFFFFFFFFFFFFA.
  - Rebuild with the macro undefined: the same MADD returns 0xF.
- Back-to-back and stall:
  - Issue 4 consecutive ops, then hold stall=1 for 3 cycles while ops are in stages 2–4.
  - Results appear in order, each exactly 3 cycles late; ready and mult_result are stable through the stall.
- Flush and reset:
  - flush=1 with 3 ops in flight -> active=0 next cycle; no ready pulse for those ops; the next op completes normally.
  - Assert rst mid-flight between clock edges -> outputs become 0 before the next edge.
- WIDTH=16 random sweep: 10k signed/unsigned/MADD/MSUB ops with random stall/flush -> every result matches a reference model computed modulo 2^32.

Source files
------------

// File: rtl/musb_mult_accum.sv
`default_nettype none
// ============================================================================
// Module   : musb_mult_accum
// Purpose  : 4-stage pipelined signed/unsigned WIDTH x WIDTH multiplier with
//            optional multiply-add / multiply-subtract for the MUSB execute
//            stage. One result per accepted operation; stall freezes the
//            pipe, flush kills everything in flight.
// Config   : MUSB_MULT_ACCUM_EN - when defined, op selects MUL/MADD/MSUB and
//            the accum_in/op pipeline registers plus the accumulate adder are
//            built. When undefined every operation is a plain MUL.
// Ports    : clk, rst (async, active-high)
//            input_a, input_b   - WIDTH-bit operands
//            accum_in           - 2*WIDTH-bit accumulator operand
//            signed_operation   - 1: two's-complement operands
//            op                 - 00 MUL, 01 MADD, 10 MSUB, 11 MUL
//            enable_op          - valid operation this cycle
//            stall, flush       - pipeline control (flush wins over stall)
//            mult_result        - registered 2*WIDTH-bit result
//            active             - any stage holds a valid operation
//            ready              - mult_result holds a valid result
// Revision : 1.0 - initial release
// ============================================================================
module musb_mult_accum #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     input_a,
  input  logic [WIDTH-1:0]     input_b,
  input  logic [2*WIDTH-1:0]   accum_in,
  input  logic                 signed_operation,
  input  logic [1:0]           op,
  input  logic                 enable_op,
  input  logic                 stall,
  input  logic                 flush,
  output logic [2*WIDTH-1:0]   mult_result,
  output logic                 active,
  output logic                 ready
);

  localparam int HALF = WIDTH / 2;
  localparam int DW   = 2 * WIDTH;

  // Data moves only on edges that neither stall nor flush.
  logic w_adv;
  assign w_adv = ~stall & ~flush;

  // ---------------- Stage 1: magnitudes ----------------
  // Sign-extend before negating so -2^(WIDTH-1) yields its exact magnitude.
  logic             w_sign_a, w_sign_b;
  logic [WIDTH:0]   w_a_ext, w_b_ext, w_mag_a, w_mag_b;

  assign w_sign_a = signed_operation & input_a[WIDTH-1];
  assign w_sign_b = signed_operation & input_b[WIDTH-1];
  assign w_a_ext  = {w_sign_a, input_a};
  assign w_b_ext  = {w_sign_b, input_b};
  assign w_mag_a  = w_sign_a ? -w_a_ext : w_a_ext;
  assign w_mag_b  = w_sign_b ? -w_b_ext : w_b_ext;

  logic [3:0]       r_valid;
  logic [WIDTH:0]   r_mag_a, r_mag_b;
  logic             r_sign_p1, r_sign_p2, r_sign_p3;

  // ---------------- Stage 2: partial products ----------------
  logic [WIDTH-1:0] w_ll, w_hh;
  logic [WIDTH:0]   w_lh, w_hl;

  assign w_ll = {{HALF{1'b0}}, r_mag_a[HALF-1:0]} * {{HALF{1'b0}}, r_mag_b[HALF-1:0]};
  assign w_lh = {{(HALF+1){1'b0}}, r_mag_a[HALF-1:0]} * {{HALF{1'b0}}, r_mag_b[WIDTH:HALF]};
  assign w_hl = {{HALF{1'b0}}, r_mag_a[WIDTH:HALF]} * {{(HALF+1){1'b0}}, r_mag_b[HALF-1:0]};
  assign w_hh = {{HALF{1'b0}}, r_mag_a[WIDTH-1:HALF]} * {{HALF{1'b0}}, r_mag_b[WIDTH-1:HALF]};

  logic [WIDTH-1:0] r_ll2, r_hh2;
  logic [WIDTH:0]   r_lh2, r_hl2;

  // ---------------- Stage 3: middle sum ----------------
  logic [WIDTH-1:0] r_ll3, r_hh3;
  logic [WIDTH:0]   r_mid3;

  // ---------------- Stage 4: recombine, sign, accumulate ----------------
  logic [WIDTH+HALF-1:0] w_upper;
  logic [DW-1:0]         w_p, w_sp, w_res;

  assign w_upper = {r_hh3, r_ll3[WIDTH-1:HALF]} + {{(HALF-1){1'b0}}, r_mid3};
  assign w_p     = {w_upper, r_ll3[HALF-1:0]};
  assign w_sp    = r_sign_p3 ? -w_p : w_p;

`ifdef MUSB_MULT_ACCUM_EN
  logic [1:0]    r_op1, r_op2, r_op3;
  logic [DW-1:0] r_acc1, r_acc2, r_acc3;

  always_comb begin
    w_res = w_sp;
    case (r_op3)
      2'b01:   w_res = r_acc3 + w_sp;
      2'b10:   w_res = r_acc3 - w_sp;
      default: w_res = w_sp;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_acc1 <= accum_in;
      r_acc2 <= r_acc1;
      r_acc3 <= r_acc2;
    end
  end
`else
  // op and accum_in have no function in the MUL-only build.
  logic w_unused;
  assign w_unused = ^{op, accum_in};
  assign w_res    = w_sp;
`endif

  // Control, sign and result registers: cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= '0;
      r_sign_p1   <= 1'b0;
      r_sign_p2   <= 1'b0;
      r_sign_p3   <= 1'b0;
      mult_result <= '0;
`ifdef MUSB_MULT_ACCUM_EN
      r_op1       <= 2'b00;
      r_op2       <= 2'b00;
      r_op3       <= 2'b00;
`endif
    end else begin
      if (flush) begin
        r_valid <= '0;
      end else if (!stall) begin
        r_valid <= {r_valid[2:0], enable_op};
      end
      if (w_adv) begin
        r_sign_p1   <= w_sign_a ^ w_sign_b;
        r_sign_p2   <= r_sign_p1;
        r_sign_p3   <= r_sign_p2;
        mult_result <= w_res;
`ifdef MUSB_MULT_ACCUM_EN
        r_op1       <= op;
        r_op2       <= r_op1;
        r_op3       <= r_op2;
`endif
      end
    end
  end

  // Pure datapath registers: no reset needed, valid flags gate them.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_mag_a <= w_mag_a;
      r_mag_b <= w_mag_b;
      r_ll2   <= w_ll;
      r_lh2   <= w_lh;
      r_hl2   <= w_hl;
      r_hh2   <= w_hh;
      r_ll3   <= r_ll2;
      r_hh3   <= r_hh2;
      r_mid3  <= r_lh2 + r_hl2;
    end
  end

  assign active = |r_valid;
  assign ready  = r_valid[3];

endmodule
`default_nettype wire

// File: tb/tb_musb_mult_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_musb_mult_accum
// Purpose  : Self-checking bench for musb_mult_accum (WIDTH=32). Vector table
//            of known products, hand sequences for stall/flush/reset, and a
//            randomized run scored against a behavioural model.
// Config   : follows MUSB_MULT_ACCUM_EN to pick accumulate expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_musb_mult_accum;

  localparam int W = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [W-1:0]    input_a, input_b;
  logic [2*W-1:0]  accum_in;
  logic            signed_operation;
  logic [1:0]      op;
  logic            enable_op, stall, flush;
  logic [2*W-1:0]  mult_result;
  logic            active, ready;

  always #5 clk = ~clk;

  musb_mult_accum #(.WIDTH(W)) dut (
    .clk              (clk),
    .rst              (rst),
    .input_a          (input_a),
    .input_b          (input_b),
    .accum_in         (accum_in),
    .signed_operation (signed_operation),
    .op               (op),
    .enable_op        (enable_op),
    .stall            (stall),
    .flush            (flush),
    .mult_result      (mult_result),
    .active           (active),
    .ready            (ready)
  );

`ifdef MUSB_MULT_ACCUM_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] acc;
    logic           sgn;
    logic [1:0]     op;
    logic [2*W-1:0] exp_acc;   // expected with accumulate built
    logic [2*W-1:0] exp_mul;   // expected in MUL-only build
  } vec_t;

  typedef struct {
    logic [2*W-1:0] val;
    int             due;
  } sb_t;

  vec_t vecs[10];
  sb_t  sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   adv_cnt = 0;
  logic exp_ready = 1'b0;

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2*W-1:0] acc, input logic sgn,
                                           input logic [1:0] o);
    logic [2*W-1:0] ea, eb, p;
    ea = sgn ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    eb = sgn ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    p  = ea * eb;
    if (ACC_EN && o == 2'b01) return acc + p;
    if (ACC_EN && o == 2'b10) return acc - p;
    return p;
  endfunction

  // One clock: drive at negedge, score just after the rising edge.
  task automatic step(input logic en, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2*W-1:0] acc, input logic sg, input logic [1:0] o,
                      input logic st, input logic fl, input logic [2*W-1:0] expv);
    logic [2*W-1:0] prev_res;
    sb_t e;
    @(negedge clk);
    enable_op = en; input_a = a; input_b = b; accum_in = acc;
    signed_operation = sg; op = o; stall = st; flush = fl;
    prev_res = mult_result;
    @(posedge clk);
    #1;
    if (fl) begin
      sb.delete();
      exp_ready = 1'b0;
      chk("flush_active", {63'd0, active}, 64'd0);
    end else if (!st) begin
      adv_cnt++;
      if (en) sb.push_back('{val: expv, due: adv_cnt + 3});
      if (sb.size() > 0 && sb[0].due == adv_cnt) begin
        e = sb.pop_front();
        exp_ready = 1'b1;
        chk("result", mult_result, e.val);
      end else begin
        exp_ready = 1'b0;
      end
    end else begin
      chk("stall_hold", mult_result, prev_res);
    end
    chk("ready", {63'd0, ready}, {63'd0, exp_ready});
    chk("active", {63'd0, active}, {63'd0, (sb.size() > 0) || exp_ready});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, 2'b00, 1'b0, 1'b0, '0);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] acc,
                       input logic sg, input logic [1:0] o);
    step(1'b1, a, b, acc, sg, o, 1'b0, 1'b0, model(a, b, acc, sg, o));
  endtask

  initial begin
    vecs[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0, 1'b0, 2'b00, 64'hFFFFFFFE00000001, 64'hFFFFFFFE00000001};
    vecs[1] = '{32'h80000000, 32'h80000000, 64'h0, 1'b1, 2'b00, 64'h4000000000000000, 64'h4000000000000000};
    vecs[2] = '{32'hFFFFFFFF, 32'h00000007, 64'h0, 1'b1, 2'b00, 64'hFFFFFFFFFFFFFFF9, 64'hFFFFFFFFFFFFFFF9};
    vecs[3] = '{32'h00000003, 32'h00000005, 64'h1, 1'b1, 2'b01, 64'h0000000000000010, 64'h000000000000000F};
    vecs[4] = '{32'h00000002, 32'h00000003, 64'h0, 1'b1, 2'b10, 64'hFFFFFFFFFFFFFFFA, 64'h0000000000000006};
    vecs[5] = '{32'h80000000, 32'h00000001, 64'h0, 1'b1, 2'b00, 64'hFFFFFFFF80000000, 64'hFFFFFFFF80000000};
    vecs[6] = '{32'h7FFFFFFF, 32'h80000000, 64'h0, 1'b1, 2'b00, 64'hC000000080000000, 64'hC000000080000000};
    vecs[7] = '{32'h00000003, 32'hFFFFFFFE, 64'h5, 1'b1, 2'b11, 64'hFFFFFFFFFFFFFFFA, 64'hFFFFFFFFFFFFFFFA};
    vecs[8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'h100, 1'b1, 2'b01, 64'h0000000000000101, 64'h0000000000000001};
    vecs[9] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0, 1'b0, 2'b10, 64'h00000001FFFFFFFF, 64'hFFFFFFFE00000001};

    rst = 1'b1; enable_op = 1'b0; stall = 1'b0; flush = 1'b0;
    input_a = '0; input_b = '0; accum_in = '0; signed_operation = 1'b0; op = 2'b00;
    #1;
    chk("reset_result", mult_result, 64'd0);
    chk("reset_ready",  {63'd0, ready},  64'd0);
    chk("reset_active", {63'd0, active}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    // Table vectors, issued back-to-back.
    for (int i = 0; i < 10; i++)
      step(1'b1, vecs[i].a, vecs[i].b, vecs[i].acc, vecs[i].sgn, vecs[i].op, 1'b0, 1'b0,
           ACC_EN ? vecs[i].exp_acc : vecs[i].exp_mul);
    idle(4);

    // Four consecutive ops, then a 3-cycle stall with ops in stages 2-4.
    issue(32'd11, 32'd13, 64'd0, 1'b0, 2'b00);
    issue(32'hFFFFFFF0, 32'd3, 64'd100, 1'b1, 2'b01);
    issue(32'h12345678, 32'h9ABCDEF0, 64'd7, 1'b0, 2'b10);
    issue(32'd1, 32'hFFFFFFFF, 64'd0, 1'b1, 2'b00);
    for (int i = 0; i < 3; i++) step(1'b1, 32'd9, 32'd9, '0, 1'b0, 2'b00, 1'b1, 1'b0, '0);
    idle(2);
    for (int i = 0; i < 2; i++) step(1'b0, '0, '0, '0, 1'b0, 2'b00, 1'b1, 1'b0, '0);
    idle(3);

    // Flush with three ops in flight; the op presented with flush is dropped.
    issue(32'd5, 32'd6, 64'd0, 1'b0, 2'b00);
    issue(32'd7, 32'd8, 64'd0, 1'b0, 2'b00);
    issue(32'd9, 32'd10, 64'd0, 1'b0, 2'b00);
    step(1'b1, 32'd2, 32'd2, '0, 1'b0, 2'b00, 1'b0, 1'b1, '0);
    idle(4);
    issue(32'd21, 32'd2, 64'd0, 1'b0, 2'b00);
    idle(4);

    // Flush together with stall: flush wins.
    issue(32'd3, 32'd3, 64'd0, 1'b0, 2'b00);
    step(1'b0, '0, '0, '0, 1'b0, 2'b00, 1'b1, 1'b1, '0);
    idle(4);

    // Asynchronous reset between edges while a result is visible.
    issue(32'h1234, 32'h5678, 64'd0, 1'b0, 2'b00);
    issue(32'd77, 32'd77, 64'd0, 1'b0, 2'b00);
    issue(32'd99, 32'd99, 64'd0, 1'b0, 2'b00);
    idle(1);
    chk("pre_reset_ready", {63'd0, ready}, 64'd1);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("async_rst_result", mult_result, 64'd0);
    chk("async_rst_ready",  {63'd0, ready},  64'd0);
    chk("async_rst_active", {63'd0, active}, 64'd0);
    @(negedge clk); rst = 1'b0;
    sb.delete(); exp_ready = 1'b0;
    idle(4);

    // Random sweep against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0]   ra, rb;
      logic [2*W-1:0] racc;
      logic           rs, ren, rst_l, rfl;
      logic [1:0]     ro;
      ra   = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      rb   = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
      racc = {$urandom, $urandom};
      rs   = 1'($urandom_range(0, 1));
      ro   = 2'($urandom_range(0, 3));
      ren  = ($urandom_range(0, 3) != 0);
      rst_l = ($urandom_range(0, 7) == 0);
      rfl  = ($urandom_range(0, 31) == 0);
      step(ren, ra, rb, racc, rs, ro, rst_l, rfl, model(ra, rb, racc, rs, ro));
    end
    idle(6);
    chk("drain_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
